// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter sharing one combinational ALU among
// NREQ requesters, with a single-entry response register (latency 1).
// Optional build macro ALU_ARB_STATS_EN adds per-requester grant counters
// (grant_cnt output, stats_clr input).
module alu_share_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [12*NREQ-1:0]   req_op,
  input  logic [32*NREQ-1:0]   req_src1,
  input  logic [32*NREQ-1:0]   req_src2,
  output logic [11:0]          alu_op,
  output logic [31:0]          alu_src1,
  output logic [31:0]          alu_src2,
  input  logic [31:0]          alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_result
`ifdef ALU_ARB_STATS_EN
  ,
  input  logic                 stats_clr,
  output logic [32*NREQ-1:0]   grant_cnt
`endif
);

  // Width of an index into the request vectors.
  localparam int SW = $clog2(NREQ);

  logic [IDW-1:0] last_gnt;
  logic           can_issue;
  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;

  // The slot can accept a new result when empty or being drained this cycle.
  assign can_issue = !rsp_valid || rsp_ready;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    if (can_issue) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (int'(last_gnt) + k) % NREQ;
        if (!gnt_found && req_valid[SW'(idx)]) begin
          gnt_found = 1'b1;
          gnt_idx   = IDW'(idx);
        end
      end
    end
  end

  // One-hot grant and operand mux; the ALU sees all zeros when idle.
  always_comb begin
    req_ready = '0;
    alu_op    = '0;
    alu_src1  = '0;
    alu_src2  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_found && gnt_idx == IDW'(i)) begin
        req_ready[SW'(i)] = 1'b1;
        alu_op            = req_op[12*i +: 12];
        alu_src1          = req_src1[32*i +: 32];
        alu_src2          = req_src2[32*i +: 32];
      end
    end
  end

  // Response slot and priority pointer; a grant reloads the slot even while
  // it is being drained, so back-to-back issue has no bubble.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: state registers update with non-blocking assignments so every
      // flop samples pre-edge values regardless of statement order.
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      last_gnt   <= IDW'(NREQ - 1);
    end else if (gnt_found) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= gnt_idx;
      rsp_result <= alu_result;
      last_gnt   <= gnt_idx;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [31:0] cnt [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    // Per-requester grant counter; clear wins over increment, wraps at 2^32.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        // NOTE: this register array is small and observable, so each entry
        // is reset explicitly rather than left as uninitialised storage.
        cnt[g] <= '0;
      end else if (stats_clr) begin
        cnt[g] <= '0;
      end else if (gnt_found && gnt_idx == IDW'(g)) begin
        cnt[g] <= cnt[g] + 32'd1;
      end
    end

    assign grant_cnt[32*g +: 32] = cnt[g];
  end
`endif

endmodule
